// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one registered ALU through an IDLE/EXEC/RESP FSM.
// ALU_ARB_ROUND_ROBIN_EN selects alternating grants; default is fixed priority to requester 0.

`ifndef CPU_WORD_WIDTH
`define CPU_WORD_WIDTH 32
`endif
`ifndef CPU_ENUM_ALU_OPER_SIZE_MSB_POS
`define CPU_ENUM_ALU_OPER_SIZE_MSB_POS 3
`endif
`ifndef CPU_ENUM_FLAGS_POS_MSB_POS
`define CPU_ENUM_FLAGS_POS_MSB_POS 3
`endif

package alu_arb_pkg;
  typedef enum logic [3:0] {
    Alu_Add = 4'd0,
    Alu_Sub = 4'd1,
    Alu_Adc = 4'd2,
    Alu_Sbc = 4'd3,
    Alu_And = 4'd4,
    Alu_Or  = 4'd5,
    Alu_Xor = 4'd6,
    Alu_Shl = 4'd7,
    Alu_Shr = 4'd8
  } alu_oper_e;

  localparam int FlagZ = 0;
  localparam int FlagC = 1;
  localparam int FlagV = 2;
  localparam int FlagN = 3;
endpackage

// Combinational ALU; carry after subtract means "no borrow".
// Shifts move a by one bit, the bit shifted out lands in FlagC.
module alu
  import alu_arb_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int OPER_W  = 4,
  parameter int FLAGS_W = 4
) (
  input  logic [WORD_W-1:0]  a,
  input  logic [WORD_W-1:0]  b,
  input  logic [OPER_W-1:0]  oper,
  input  logic [FLAGS_W-1:0] flags_in,
  output logic [WORD_W-1:0]  out,
  output logic [FLAGS_W-1:0] flags_out
);
  localparam int M = WORD_W - 1;

  logic [WORD_W:0]   sum;
  logic [WORD_W-1:0] res;
  logic              c;
  logic              v;
  logic [WORD_W:0]   cin;

  assign cin = (WORD_W+1)'(flags_in[FlagC]);

  // Operation decode and flag generation.
  always_comb begin
    sum = '0;
    res = '0;
    c   = flags_in[FlagC];
    v   = flags_in[FlagV];
    case (oper)
      OPER_W'(Alu_Add): begin
        sum = {1'b0, a} + {1'b0, b};
        res = sum[M:0];
        c   = sum[WORD_W];
        v   = (a[M] == b[M]) && (res[M] != a[M]);
      end
      OPER_W'(Alu_Adc): begin
        sum = {1'b0, a} + {1'b0, b} + cin;
        res = sum[M:0];
        c   = sum[WORD_W];
        v   = (a[M] == b[M]) && (res[M] != a[M]);
      end
      OPER_W'(Alu_Sub): begin
        sum = {1'b0, a} + {1'b0, ~b}
            + (WORD_W+1)'(1);
        res = sum[M:0];
        c   = sum[WORD_W];
        v   = (a[M] != b[M]) && (res[M] != a[M]);
      end
      OPER_W'(Alu_Sbc): begin
        sum = {1'b0, a} + {1'b0, ~b} + cin;
        res = sum[M:0];
        c   = sum[WORD_W];
        v   = (a[M] != b[M]) && (res[M] != a[M]);
      end
      OPER_W'(Alu_And): res = a & b;
      OPER_W'(Alu_Or):  res = a | b;
      OPER_W'(Alu_Xor): res = a ^ b;
      OPER_W'(Alu_Shl): begin
        res = {a[M-1:0], 1'b0};
        c   = a[M];
      end
      OPER_W'(Alu_Shr): begin
        res = {1'b0, a[M:1]};
        c   = a[0];
      end
      default: res = '0;
    endcase
    out              = res;
    flags_out        = flags_in;
    flags_out[FlagZ] = (res == '0);
    flags_out[FlagC] = c;
    flags_out[FlagV] = v;
    flags_out[FlagN] = res[M];
  end
endmodule

module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WORD_W  = `CPU_WORD_WIDTH,
  parameter int OPER_W  = `CPU_ENUM_ALU_OPER_SIZE_MSB_POS+1,
  parameter int FLAGS_W = `CPU_ENUM_FLAGS_POS_MSB_POS+1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid_0,
  input  logic               req_valid_1,
  output logic               req_ready_0,
  output logic               req_ready_1,
  input  logic [WORD_W-1:0]  req_a_0,
  input  logic [WORD_W-1:0]  req_b_0,
  input  logic [WORD_W-1:0]  req_a_1,
  input  logic [WORD_W-1:0]  req_b_1,
  input  logic [OPER_W-1:0]  req_oper_0,
  input  logic [OPER_W-1:0]  req_oper_1,
  input  logic [FLAGS_W-1:0] req_flags_0,
  input  logic [FLAGS_W-1:0] req_flags_1,
  output logic               rsp_valid_0,
  output logic               rsp_valid_1,
  input  logic               rsp_ready_0,
  input  logic               rsp_ready_1,
  output logic [WORD_W-1:0]  rsp_out,
  output logic [FLAGS_W-1:0] rsp_flags,
  output logic               busy
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q;
  logic [WORD_W-1:0]  a_q;
  logic [WORD_W-1:0]  b_q;
  logic [OPER_W-1:0]  oper_q;
  logic [FLAGS_W-1:0] flags_q;
  logic               idx_q;
  logic               last_grant_q;

  logic               both_win;
  logic               win;
  logic               accept;
  logic               rsp_take;
  logic [WORD_W-1:0]  alu_out;
  logic [FLAGS_W-1:0] alu_flags;

  alu #(
    .WORD_W (WORD_W),
    .OPER_W (OPER_W),
    .FLAGS_W(FLAGS_W)
  ) u_alu (
    .a        (a_q),
    .b        (b_q),
    .oper     (oper_q),
    .flags_in (flags_q),
    .out      (alu_out),
    .flags_out(alu_flags)
  );

`ifdef ALU_ARB_ROUND_ROBIN_EN
  assign both_win = ~last_grant_q;
`else
  // last_grant is kept up to date but never steers the grant here.
  assign both_win = 1'b0 & last_grant_q;
`endif

  // Winner select among pending requesters.
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      req_valid_0 && req_valid_1:  win = both_win;
      !req_valid_0 && req_valid_1: win = 1'b1;
      default:                     win = 1'b0;
    endcase
  end

  assign accept = rst_n && (state_q == IDLE)
               && (req_valid_0 || req_valid_1);
  assign req_ready_0 = accept && !win;
  assign req_ready_1 = accept && win;

  assign rsp_valid_0 = (state_q == RESP) && !idx_q;
  assign rsp_valid_1 = (state_q == RESP) && idx_q;
  assign busy        = (state_q != IDLE);

  assign rsp_take = idx_q ? rsp_ready_1 : rsp_ready_0;

  // Accept, execute, then hold the result until its owner takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      idx_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      oper_q       <= '0;
      flags_q      <= '0;
      rsp_out      <= '0;
      rsp_flags    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            idx_q        <= win;
            last_grant_q <= win;
            a_q          <= win ? req_a_1 : req_a_0;
            b_q          <= win ? req_b_1 : req_b_0;
            oper_q       <= win ? req_oper_1
                                : req_oper_0;
            flags_q      <= win ? req_flags_1
                                : req_flags_0;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          rsp_out   <= alu_out;
          rsp_flags <= alu_flags;
          state_q   <= RESP;
        end
        RESP: begin
          if (rsp_take) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table plus
// arbitration, back-pressure and mid-flight reset sequences.

module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int W  = 32;
  localparam int OW = 4;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid_0, req_valid_1;
  logic          req_ready_0, req_ready_1;
  logic [W-1:0]  req_a_0, req_b_0, req_a_1, req_b_1;
  logic [OW-1:0] req_oper_0, req_oper_1;
  logic [FW-1:0] req_flags_0, req_flags_1;
  logic          rsp_valid_0, rsp_valid_1;
  logic          rsp_ready_0, rsp_ready_1;
  logic [W-1:0]  rsp_out;
  logic [FW-1:0] rsp_flags;
  logic          busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(
    .WORD_W (W),
    .OPER_W (OW),
    .FLAGS_W(FW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid_0(req_valid_0),
    .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0),
    .req_ready_1(req_ready_1),
    .req_a_0    (req_a_0),
    .req_b_0    (req_b_0),
    .req_a_1    (req_a_1),
    .req_b_1    (req_b_1),
    .req_oper_0 (req_oper_0),
    .req_oper_1 (req_oper_1),
    .req_flags_0(req_flags_0),
    .req_flags_1(req_flags_1),
    .rsp_valid_0(rsp_valid_0),
    .rsp_valid_1(rsp_valid_1),
    .rsp_ready_0(rsp_ready_0),
    .rsp_ready_1(rsp_ready_1),
    .rsp_out    (rsp_out),
    .rsp_flags  (rsp_flags),
    .busy       (busy)
  );

  typedef struct {
    logic          sel;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [OW-1:0] op;
    logic [FW-1:0] fi;
    logic [W-1:0]  eo;
    logic [FW-1:0] ef;
  } vec_t;

  vec_t vt [12];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  task automatic drive_ops(input logic [W-1:0] a,
                           input logic [W-1:0] b,
                           input logic [OW-1:0] op,
                           input logic [FW-1:0] fi);
    req_a_0 = a; req_b_0 = b;
    req_oper_0 = op; req_flags_0 = fi;
    req_a_1 = a; req_b_1 = b;
    req_oper_1 = op; req_flags_1 = fi;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vt[i];
    @(negedge clk);
    drive_ops(v.a, v.b, v.op, v.fi);
    req_valid_0 = !v.sel;
    req_valid_1 = v.sel;
    #1;
    check($sformatf("v%0d_ready", i),
          32'({req_ready_1, req_ready_0}),
          v.sel ? 32'd2 : 32'd1);
    @(negedge clk);
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    #1;
    check($sformatf("v%0d_exec_busy", i),
          32'({busy, rsp_valid_1, rsp_valid_0}),
          32'd4);
    @(negedge clk);
    #1;
    check($sformatf("v%0d_rsp_valid", i),
          32'({rsp_valid_1, rsp_valid_0}),
          v.sel ? 32'd2 : 32'd1);
    check($sformatf("v%0d_out", i), rsp_out, v.eo);
    check($sformatf("v%0d_flags", i),
          32'(rsp_flags), 32'(v.ef));
  endtask

  int exp_g [4];
  int g;
  int last_c;

  initial begin
    // flags vectors are {N, V, C, Z}
    vt[0]  = '{1'b0, 32'd5, 32'd3, Alu_Sub,
               4'b0000, 32'd2, 4'b0010};
    vt[1]  = '{1'b1, 32'd3, 32'd3, Alu_Sub,
               4'b0000, 32'd0, 4'b0011};
    vt[2]  = '{1'b0, 32'hFFFF_FFFF, 32'd1, Alu_Add,
               4'b0000, 32'd0, 4'b0011};
    vt[3]  = '{1'b1, 32'h7FFF_FFFF, 32'd1, Alu_Add,
               4'b0000, 32'h8000_0000, 4'b1100};
    vt[4]  = '{1'b0, 32'd1, 32'd1, Alu_Adc,
               4'b0010, 32'd3, 4'b0000};
    vt[5]  = '{1'b1, 32'd5, 32'd3, Alu_Sbc,
               4'b0000, 32'd1, 4'b0010};
    vt[6]  = '{1'b0, 32'hF0F0, 32'hFF00, Alu_And,
               4'b0000, 32'hF000, 4'b0000};
    vt[7]  = '{1'b1, 32'h0F, 32'hF0, Alu_Or,
               4'b0110, 32'hFF, 4'b0110};
    vt[8]  = '{1'b0, 32'h55, 32'h55, Alu_Xor,
               4'b0000, 32'd0, 4'b0001};
    vt[9]  = '{1'b1, 32'h8000_0001, 32'd0, Alu_Shl,
               4'b0000, 32'd2, 4'b0010};
    vt[10] = '{1'b0, 32'd3, 32'd0, Alu_Shr,
               4'b0000, 32'd1, 4'b0010};
    vt[11] = '{1'b0, 32'h8000_0000, 32'd1, Alu_Sub,
               4'b0000, 32'h7FFF_FFFF, 4'b0110};

`ifdef ALU_ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif

    rst_n = 1'b0;
    req_valid_0 = 1'b1;
    req_valid_1 = 1'b1;
    rsp_ready_0 = 1'b1;
    rsp_ready_1 = 1'b1;
    drive_ops(32'd5, 32'd3, Alu_Sub, 4'b0000);

    // reset state with requests pending
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready",
          32'({req_ready_1, req_ready_0}), 32'd0);
    check("rst_rsp_valid",
          32'({rsp_valid_1, rsp_valid_0}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out", rsp_out, 32'd0);
    check("rst_flags", 32'(rsp_flags), 32'd0);
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(i);

    // contention with both requesters always pending
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_valid_0 = 1'b1;
    req_valid_1 = 1'b1;
    drive_ops(32'd9, 32'd4, Alu_Sub, 4'b0000);
    g = 0;
    last_c = 0;
    for (int c = 0; c < 20 && g < 4; c++) begin
      #1;
      check("arb_excl",
            32'(req_ready_0 & req_ready_1), 32'd0);
      if (req_ready_0 || req_ready_1) begin
        check($sformatf("arb_grant%0d", g),
              32'(req_ready_1), 32'(exp_g[g]));
        check($sformatf("arb_gap%0d", g),
              32'(c - last_c),
              (g == 0) ? 32'd0 : 32'd3);
        last_c = c;
        g++;
      end
      @(negedge clk);
    end
    check("arb_count", 32'(g), 32'd4);
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;

    for (int c = 0; c < 6 && busy; c++)
      @(negedge clk);
    #1;
    check("arb_idle", 32'(busy), 32'd0);

    // back-pressure on requester 0, stray ready on 1
    @(negedge clk);
    drive_ops(32'd1, 32'd2, Alu_Sub, 4'b0000);
    rsp_ready_0 = 1'b0;
    rsp_ready_1 = 1'b1;
    req_valid_0 = 1'b1;
    #1;
    check("hold_accept",
          32'({req_ready_1, req_ready_0}), 32'd1);
    @(negedge clk);
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b1;
    req_a_1 = 32'd7;
    req_b_1 = 32'd2;
    req_oper_1 = Alu_Add;
    #1;
    check("hold_exec_ready1", 32'(req_ready_1), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("hold%0d_valid", c),
            32'({rsp_valid_1, rsp_valid_0}), 32'd1);
      check($sformatf("hold%0d_out", c),
            rsp_out, 32'hFFFF_FFFF);
      check($sformatf("hold%0d_flags", c),
            32'(rsp_flags), 32'b1000);
      check($sformatf("hold%0d_busy_rdy", c),
            32'({busy, req_ready_1, req_ready_0}),
            32'd4);
    end
    @(negedge clk);
    rsp_ready_0 = 1'b1;
    #1;
    check("hold_last_valid",
          32'({rsp_valid_1, rsp_valid_0}), 32'd1);
    @(negedge clk);
    #1;
    check("hold_then_req1",
          32'({busy, req_ready_1, req_ready_0}), 32'd2);
    @(negedge clk);
    req_valid_1 = 1'b0;
    @(negedge clk);
    #1;
    check("req1_after_valid",
          32'({rsp_valid_1, rsp_valid_0}), 32'd2);
    check("req1_after_out", rsp_out, 32'd9);
    check("req1_after_flags", 32'(rsp_flags), 32'd0);

    // reset while an operation is in EXEC
    @(negedge clk);
    drive_ops(32'd4, 32'd4, Alu_Add, 4'b0000);
    req_valid_0 = 1'b1;
    #1;
    check("abort_accept",
          32'({req_ready_1, req_ready_0}), 32'd1);
    @(negedge clk);
    req_valid_0 = 1'b0;
    #1;
    check("abort_in_exec", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out", rsp_out, 32'd0);
    check("abort_flags", 32'(rsp_flags), 32'd0);
    check("abort_valid",
          32'({rsp_valid_1, rsp_valid_0}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("abort_quiet%0d", c),
            32'({busy, rsp_valid_1, rsp_valid_0}),
            32'd0);
      @(negedge clk);
    end
    req_valid_0 = 1'b1;
    req_valid_1 = 1'b1;
    #1;
    check("abort_first_grant",
          32'({req_ready_1, req_ready_0}), 32'd1);
    @(negedge clk);
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WORD_W, default `CPU_WORD_WIDTH, operand/result width.
REQ-002 Parameter: OPER_W, default `CPU_ENUM_ALU_OPER_SIZE_MSB_POS+1, ALU operation code width.
REQ-003 Parameter: FLAGS_W, default `CPU_ENUM_FLAGS_POS_MSB_POS+1, flags vector width (FlagZ/FlagC/FlagV/FlagN).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req_valid_0, req_valid_1  in  1 each  requester k has an operation pending.
REQ-007 req_ready_0, req_ready_1  out  1 each  requester k's operation accepted this cycle.
REQ-008 req_a_k, req_b_k  in  WORD_W each  operands for requester k.
REQ-009 req_oper_k  in  OPER_W  ALU operation for requester k.
REQ-010 req_flags_k  in  FLAGS_W  flags_in for requester k.
REQ-011 rsp_valid_0, rsp_valid_1  out  1 each  result for requester k available.
REQ-012 rsp_ready_0, rsp_ready_1  in  1 each  requester k consumes result.
REQ-013 rsp_out  out  WORD_W  shared registered ALU result.
REQ-014 rsp_flags  out  FLAGS_W  shared registered ALU flags_out.
REQ-015 busy  out  1  high whenever state is not IDLE.

Function
REQ-016 Block SHALL contain exactly one Alu instance driven only from internal operand registers (a, b, oper, flags_in).
REQ-017 FSM states SHALL be IDLE, EXEC, RESP; encoding is implementation choice.
REQ-018 IDLE: if any req_valid_k, SHALL select winner per REQ-024, assert req_ready_winner combinationally in the same cycle, latch winner's a/b/oper/flags and its index, go EXEC; else stay IDLE.
REQ-019 req_ready_k SHALL be asserted only in IDLE, only for the winner, and only while req_valid_k is high; never both high.
REQ-020 EXEC: SHALL register Alu out and flags_out into rsp_out/rsp_flags, go RESP (one cycle, unconditional).
REQ-021 RESP: SHALL assert rsp_valid for the latched index only; go IDLE on the cycle rsp_ready of that index is high; otherwise hold.
REQ-022 rsp_out, rsp_flags, latched index SHALL stay stable throughout RESP; rsp_ready of the non-granted requester SHALL be ignored.
REQ-023 Latency: accept at cycle N -> rsp_valid at N+2; with rsp_ready tied high, next accept no earlier than N+3 (throughput one op per 3 cycles).
REQ-024 Arbitration: both valid in IDLE -> winner per REQ-032/033; single valid -> that requester wins.
REQ-025 Requests changing while not accepted SHALL not affect state; inputs sampled only on accept.
REQ-026 last_grant register SHALL update to winner index on every accept.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, last_grant 1 (so requester 0 has priority first), operand registers 0, rsp_out 0, rsp_flags 0.
REQ-028 During reset: req_ready_k 0, rsp_valid_k 0, busy 0.
REQ-029 Reset mid-EXEC or mid-RESP SHALL discard the in-flight operation; no rsp_valid after release for it.
REQ-030 First accept possible on first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro ALU_ARB_ROUND_ROBIN_EN selects arbitration policy.
REQ-032 Defined: both valid -> requester other than last_grant wins (alternating).
REQ-033 Undefined: fixed priority, requester 0 always wins; last_grant still maintained but unused for selection.

Verification
REQ-034 After reset, req0 only: a=5, b=3, oper=Alu_Sub, flags=0000 -> req_ready_0 at N, rsp_valid_0 at N+2, rsp_out=2, FlagZ=0, FlagC=1.
REQ-035 req1 only: a=3, b=3, Alu_Sub -> rsp_valid_1 at N+2, rsp_out=0, FlagZ=1, FlagC=1; rsp_valid_0 stays 0.
REQ-036 Both valid continuously, rsp_ready high, ROUND_ROBIN_EN defined -> grants 0,1,0,1 every 3 cycles; undefined -> grants 0,0,0,0, req_ready_1 never high.
REQ-037 rsp_ready_0 low 5 cycles in RESP (a=1,b=2 Alu_Sub) -> rsp_valid_0, rsp_out=all-ones, FlagC=0, FlagN=1 held stable 5 cycles; busy high; no req_ready.
REQ-038 rst_n pulsed low during EXEC -> outputs zero immediately; after release, no rsp_valid for aborted op; simultaneous requests grant 0 first.
REQ-039 rsp_ready_1 high while RESP serves requester 0 -> ignored; state stays RESP until rsp_ready_0.
